// File: rtl/dm_arbiter.sv
// dm_arbiter: shares one single-port data RAM between two lanes in program order, serialising conflicts with a one-cycle lockstep stall.
module dm_arbiter #(
  parameter int AW = 9,
  parameter int DW = 16,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] p0_DM_maddr,
  input  logic [AW-1:0] p1_DM_maddr,
  input  logic [DW-1:0] p0_DM_wdata,
  input  logic [DW-1:0] p1_DM_wdata,
  input  logic          p0_DM_write_mem,
  input  logic          p1_DM_write_mem,
  input  logic          p0_DM_read_mem,
  input  logic          p1_DM_read_mem,
  output logic [DW-1:0] p0_DM_rdata,
  output logic [DW-1:0] p1_DM_rdata,
  output logic          p0_DM_rvalid,
  output logic          p1_DM_rvalid,
  output logic          stall,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_write,
  input  logic [DW-1:0] mem_rdata,
  output logic [CW-1:0] conflict_count
);
  localparam logic IDLE   = 1'b0;
  localparam logic SECOND = 1'b1;
  logic          state;
  logic          hold_write;
  logic [AW-1:0] hold_addr;
  logic [DW-1:0] hold_wdata;
  logic          tag0, tag1;
  logic [DW-1:0] rdata0_q, rdata1_q;
  logic          req0, req1, merge, conflict, idle_st, second_st, own0, own1;
  always_comb begin
    req0      = p0_DM_read_mem | p0_DM_write_mem;
    req1      = p1_DM_read_mem | p1_DM_write_mem;
    merge     = p0_DM_read_mem & p1_DM_read_mem & (p0_DM_maddr == p1_DM_maddr);
    conflict  = req0 & req1 & ~merge;
    idle_st   = rst & (state == IDLE);
    second_st = rst & (state == SECOND);
    stall     = idle_st & conflict;
    // p0 is older, so it always wins the first slot; SECOND replays only the held p1 access
    mem_write = second_st ? hold_write : idle_st & (req0 ? p0_DM_write_mem : p1_DM_write_mem);
    mem_addr  = second_st ? hold_addr : !idle_st ? '0 : req0 ? p0_DM_maddr : req1 ? p1_DM_maddr : '0;
    mem_wdata = !mem_write ? '0 : second_st ? hold_wdata : req0 ? p0_DM_wdata : p1_DM_wdata;
    own0      = idle_st & p0_DM_read_mem;
    own1      = second_st ? ~hold_write : idle_st & p1_DM_read_mem & (merge | ~req0);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      hold_write     <= 1'b0;
      hold_addr      <= '0;
      hold_wdata     <= '0;
      tag0           <= 1'b0;
      tag1           <= 1'b0;
      rdata0_q       <= '0;
      rdata1_q       <= '0;
      conflict_count <= '0;
    end else begin
      state <= stall ? SECOND : IDLE;
      if (stall) begin
        hold_write <= p1_DM_write_mem;
        hold_addr  <= p1_DM_maddr;
        hold_wdata <= p1_DM_wdata;
      end
      tag0 <= own0;
      tag1 <= own1;
      if (tag0) rdata0_q <= mem_rdata;
      if (tag1) rdata1_q <= mem_rdata;
      if (stall && conflict_count != '1) conflict_count <= conflict_count + CW'(1);
    end
  end
  assign p0_DM_rvalid = tag0;
  assign p1_DM_rvalid = tag1;
  assign p0_DM_rdata  = tag0 ? mem_rdata : rdata0_q;
  assign p1_DM_rdata  = tag1 ? mem_rdata : rdata1_q;
endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: directed bundles against a program-order memory model, checked every cycle.
module tb_dm_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  logic [8:0]  a0 = '0, a1 = '0;
  logic [15:0] d0 = '0, d1 = '0;
  logic        r0 = 1'b0, w0 = 1'b0, r1 = 1'b0, w1 = 1'b0;
  logic [15:0] rd0, rd1, mem_wdata, mem_rdata = '0;
  logic        rv0, rv1, stall, mem_write;
  logic [8:0]  mem_addr;
  logic [15:0] cnt;
  logic [15:0] s_rd0, s_rd1, s_wdata;
  logic        s_rv0, s_rv1, s_stall, s_write;
  logic [8:0]  s_addr;
  logic [1:0]  s_cnt;
  logic [15:0] ram [0:511];

  dm_arbiter dut (
    .clk(clk), .rst(rst),
    .p0_DM_maddr(a0), .p1_DM_maddr(a1), .p0_DM_wdata(d0), .p1_DM_wdata(d1),
    .p0_DM_write_mem(w0), .p1_DM_write_mem(w1), .p0_DM_read_mem(r0), .p1_DM_read_mem(r1),
    .p0_DM_rdata(rd0), .p1_DM_rdata(rd1), .p0_DM_rvalid(rv0), .p1_DM_rvalid(rv1),
    .stall(stall), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
    .mem_rdata(mem_rdata), .conflict_count(cnt)
  );

  dm_arbiter #(.CW(2)) u_sat (
    .clk(clk), .rst(rst),
    .p0_DM_maddr(a0), .p1_DM_maddr(a1), .p0_DM_wdata(d0), .p1_DM_wdata(d1),
    .p0_DM_write_mem(w0), .p1_DM_write_mem(w1), .p0_DM_read_mem(r0), .p1_DM_read_mem(r1),
    .p0_DM_rdata(s_rd0), .p1_DM_rdata(s_rd1), .p0_DM_rvalid(s_rv0), .p1_DM_rvalid(s_rv1),
    .stall(s_stall), .mem_addr(s_addr), .mem_wdata(s_wdata), .mem_write(s_write),
    .mem_rdata(16'h0000), .conflict_count(s_cnt)
  );

  always @(posedge clk) begin
    if (mem_write) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0;
  bit [15:0] ref_mem [0:511];
  bit        e_stall [0:2047];
  bit        e_mw    [0:2047];
  bit        e_rv0   [0:2047];
  bit        e_rv1   [0:2047];
  bit        e_inc   [0:2047];
  bit [8:0]  e_ma    [0:2047];
  bit [15:0] e_md    [0:2047];
  bit [15:0] e_rd0   [0:2047];
  bit [15:0] e_rd1   [0:2047];
  int        m_cnt = 0, m_cnt2 = 0;
  bit [15:0] last0 = '0, last1 = '0;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, act, exp, cyc);
    end
  endtask

  // Program-order model: p0 acts before p1; a conflicting p1 takes the following slot.
  task automatic predict(input int c, output bit cf);
    bit q0 = r0 | w0;
    bit q1 = r1 | w1;
    bit mg = r0 && r1 && (a0 == a1);
    int s;
    cf = q0 && q1 && !mg;
    s  = cf ? c + 1 : c;
    e_stall[c]  = cf;
    e_inc[c+1]  = cf;
    if (r0) begin e_rv0[c+1] = 1'b1; e_rd0[c+1] = ref_mem[a0]; end
    if (w0) begin e_mw[c] = 1'b1; e_ma[c] = a0; e_md[c] = d0; ref_mem[a0] = d0; end
    if (mg) begin e_rv1[c+1] = 1'b1; e_rd1[c+1] = ref_mem[a0]; end
    else if (r1) begin e_rv1[s+1] = 1'b1; e_rd1[s+1] = ref_mem[a1]; end
    if (w1) begin e_mw[s] = 1'b1; e_ma[s] = a1; e_md[s] = d1; ref_mem[a1] = d1; end
  endtask

  task automatic drive(input bit pr0, pw0, input logic [8:0] pa0, input logic [15:0] pd0,
                       input bit pr1, pw1, input logic [8:0] pa1, input logic [15:0] pd1);
    r0 = pr0; w0 = pw0; a0 = pa0; d0 = pd0;
    r1 = pr1; w1 = pw1; a1 = pa1; d1 = pd1;
  endtask

  task automatic bundle(input bit pr0, pw0, input logic [8:0] pa0, input logic [15:0] pd0,
                        input bit pr1, pw1, input logic [8:0] pa1, input logic [15:0] pd1);
    bit cf;
    drive(pr0, pw0, pa0, pd0, pr1, pw1, pa1, pd1);
    predict(cyc, cf);
    @(posedge clk); #1;
    if (cf) begin @(posedge clk); #1; end
  endtask

  task automatic idle();
    drive(0, 0, 9'h0, 16'h0, 0, 0, 9'h0, 16'h0);
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      m_cnt = 0; m_cnt2 = 0; last0 = '0; last1 = '0;
      chk("rst_mem_write", mem_write, 0);
      chk("rst_stall", stall, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_rvalid", {rv0, rv1}, 0);
      chk("rst_rdata0", rd0, 0);
      chk("rst_rdata1", rd1, 0);
      chk("rst_count", cnt, 0);
      chk("rst_sat_count", s_cnt, 0);
    end else begin
      if (e_inc[cyc]) begin
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt2 < 3) m_cnt2++;
      end
      if (e_rv0[cyc]) last0 = e_rd0[cyc];
      if (e_rv1[cyc]) last1 = e_rd1[cyc];
      chk("stall", stall, e_stall[cyc]);
      chk("mem_write", mem_write, e_mw[cyc]);
      chk("rvalid0", rv0, e_rv0[cyc]);
      chk("rvalid1", rv1, e_rv1[cyc]);
      chk("rdata0", rd0, last0);
      chk("rdata1", rd1, last1);
      chk("conflict_count", cnt, m_cnt);
      chk("sat_conflict_count", s_cnt, m_cnt2);
      if (e_mw[cyc]) begin
        chk("mem_addr", mem_addr, e_ma[cyc]);
        chk("mem_wdata", mem_wdata, e_md[cyc]);
      end
    end
  end

  initial begin
    bit [15:0] saved;
    bit cf;
    for (int i = 0; i < 512; i++) ram[i] = '0;
    drive(0, 1, 9'h030, 16'h9999, 0, 1, 9'h030, 16'hAAAA);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    idle();
    bundle(0, 1, 9'h010, 16'h1234, 0, 0, 9'h000, 16'h0000);
    bundle(0, 0, 9'h000, 16'h0000, 1, 0, 9'h010, 16'h0000);
    idle();
    chk("lit_p1_read_1234", rd1, 16'h1234);
    bundle(1, 0, 9'h010, 16'h0000, 1, 0, 9'h010, 16'h0000);
    idle();
    chk("lit_merge_rd0", rd0, 16'h1234);
    chk("lit_merge_rd1", rd1, 16'h1234);
    chk("lit_merge_count", cnt, 0);
    bundle(0, 1, 9'h020, 16'hBEEF, 1, 0, 9'h020, 16'h0000);
    idle();
    chk("lit_raw_rd1", rd1, 16'hBEEF);
    chk("lit_raw_count", cnt, 1);
    bundle(1, 0, 9'h020, 16'h0000, 0, 1, 9'h020, 16'hCAFE);
    idle();
    chk("lit_war_rd0", rd0, 16'hBEEF);
    chk("lit_war_ram", ram[9'h020], 16'hCAFE);
    bundle(0, 1, 9'h030, 16'h1111, 0, 1, 9'h030, 16'h2222);
    idle();
    chk("lit_waw_ram", ram[9'h030], 16'h2222);
    chk("lit_waw_count", cnt, 3);
    bundle(1, 0, 9'h030, 16'h0000, 1, 0, 9'h020, 16'h0000);
    bundle(0, 0, 9'h000, 16'h0000, 1, 0, 9'h030, 16'h0000);
    idle();
    chk("lit_b2b_rd0", rd0, 16'h2222);
    chk("lit_b2b_rd1", rd1, 16'h2222);
    chk("lit_sat_at_3", s_cnt, 3);
    chk("lit_count_4", cnt, 4);
    drive(0, 1, 9'h041, 16'h7777, 0, 1, 9'h040, 16'h5555);
    saved = ref_mem[9'h040];
    predict(cyc, cf);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    ref_mem[9'h040] = saved;
    drive(0, 0, 9'h0, 16'h0, 0, 0, 9'h0, 16'h0);
    rst = 1'b1;
    idle();
    chk("lit_rst_second_ram40", ram[9'h040], 16'h0000);
    chk("lit_rst_second_ram41", ram[9'h041], 16'h7777);
    chk("lit_rst_second_count", cnt, 0);
    bundle(1, 0, 9'h040, 16'h0000, 1, 0, 9'h041, 16'h0000);
    idle();
    chk("lit_after_rst_rd1", rd1, 16'h7777);
    for (int i = 0; i < 4; i++)
      bundle(1, 0, 9'(9'h050 + i), 16'h0000, 0, 1, 9'(9'h060 + i), 16'(16'h0A00 + i));
    idle();
    chk("lit_final_count", cnt, 5);
    chk("lit_final_sat", s_cnt, 3);
    chk("lit_final_ram63", ram[9'h063], 16'h0A03);
    idle();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule

// File: doc/dm_arbiter.md
# dm_arbiter

Shares one single-port synchronous data memory (512 x 16) between the two issue pipelines' memory stages. It serves both lanes in program order, with pipeline 0 older than pipeline 1. Same-cycle conflicts are serialised over two cycles with a lockstep stall, and identical same-cycle reads are merged into one access. It sits between the two pipelines' memory ports and the shared data RAM, replacing the per-lane memories.

## Interface
Parameters:
- AW, 9: memory word-address width.
- DW, 16: data width.
- CW, 16: width of the conflict statistics counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- p0_DM_maddr, p1_DM_maddr  in  AW  per-lane request address.
- p0_DM_wdata, p1_DM_wdata  in  DW  per-lane write data.
- p0_DM_write_mem, p1_DM_write_mem  in  1  per-lane write request.
- p0_DM_read_mem, p1_DM_read_mem  in  1  per-lane read request; a lane never asserts read and write together.
- p0_DM_rdata, p1_DM_rdata  out  DW  per-lane read data; holds the last read value returned to that lane.
- p0_DM_rvalid, p1_DM_rvalid  out  1  one-cycle pulse: the lane's read data is new this cycle.
- stall  out  1  freezes both pipelines (lockstep) for one cycle.
- mem_addr  out  AW  shared RAM address.
- mem_wdata  out  DW  shared RAM write data.
- mem_write  out  1  shared RAM write enable.
- mem_rdata  in  DW  shared RAM read data; valid the cycle after the address is presented.
- conflict_count  out  CW  saturating count of serialised (stalled) bundles.

## Operation
- reqX = pX_DM_read_mem | pX_DM_write_mem.
- merge = both lanes read and the addresses are equal.
- conflict = req0 & req1 & !merge.

States: IDLE, SECOND.

IDLE behaviour:
- Only one lane requesting: drive mem_* from that lane combinationally.
- merge: one RAM read; both lanes receive the data.
- conflict: issue p0 this cycle, capture p1 {write, addr, wdata} into the hold register, assert stall, go to SECOND.

SECOND behaviour:
- Drive mem_* from the hold register.
- Ignore all lane inputs; the re-presented p0 request was already served, and a p0 write is never repeated.
- stall = 0.
- Next state is always IDLE.

Ordering guarantees:
- p0 write then p1 read, same address: p1 reads the new data.
- p0 read then p1 write, same address: p0 reads the old data.
- Write/write, same address: p1 data persists, matching the regfile write-priority rule.

Other rules:
- mem_write = 0 whenever no write is being issued. mem_addr and mem_wdata are don't-care when idle, but are driven 0.
- Read return: a read-owner tag (p0, p1 or both) is registered at issue. In the next cycle the owning lane(s) pulse rvalid, pass mem_rdata through, and latch it into that lane's rdata hold register.
- conflict_count increments on each IDLE->SECOND transition and saturates at all-ones.

## Timing
- Reset (rst low, asynchronous) forces:
  - state IDLE; hold register and owner tag cleared;
  - stall 0, mem_write 0, mem_addr 0, mem_wdata 0;
  - both rvalid 0, both rdata 0, conflict_count 0.
- Reset in SECOND drops the held p1 access; no write reaches RAM.
- Non-conflicting access: issue in cycle t; read data and rvalid in cycle t+1.
- Conflicting bundle at t:
  - p0 issued at t; stall=1 during t.
  - p1 issued at t+1.
  - p0 rvalid at t+1 (if read); p1 rvalid at t+2 (if read).
- A new bundle arriving at t+1 is ignored; the pipelines hold it because of the stall and re-present it at t+2.
- stall is combinational from the request inputs in IDLE; it is never high in two consecutive cycles.
- rdata changes only in an rvalid cycle for that lane.
- One RAM access per cycle, maximum.

## Test plan
- Reset: hold rst=0 with requests active -> mem_write=0, stall=0, all rdata=0, conflict_count=0; first access after release proceeds normally.
- Single lanes: p0 writes 0x1234 to 0x010, next cycle p1 reads 0x010 -> one access each, no stall; p1_DM_rvalid pulses with p1_DM_rdata=0x1234.
- Merge: both lanes read 0x010 in the same cycle -> one RAM read, stall=0; both rvalid next cycle with 0x1234; conflict_count unchanged.
- Ordering conflict: p0 writes 0xBEEF to 0x020 while p1 reads 0x020 -> stall=1 for one cycle; p1 reads 0xBEEF; conflict_count=1. Repeat with p0 reading and p1 writing 0xCAFE -> p0 reads 0xBEEF, RAM ends at 0xCAFE.
- Write/write conflict to 0x030 (p0 0x1111, p1 0x2222) -> exactly two writes; re-presented p0 in SECOND is not rewritten; final RAM value 0x2222.
- Reset asserted during SECOND holding a p1 write of 0x5555 to 0x040 -> no write to 0x040; state IDLE; counter saturation verified with CW forced to 2 (value sticks at 3).
